// File: rtl/led_status_ctrl.sv
// rtl/led_status_ctrl.sv - multi-channel LED status driver (off/on/blink/stretch); optional LED_PWM_EN brightness gating
module led_status_ctrl #(
  parameter int NUM_CH        = 8,
  parameter int CLK_HZ        = 50000000,
  parameter int TICK_HZ       = 1000,
  parameter int STRETCH_TICKS = 50,
  parameter int HP_W          = 16
) (
  input  logic                  fpga_clk_50,
  input  logic                  hps_fpga_reset_n,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [HP_W-1:0]       half_period,
  input  logic [NUM_CH-1:0]     event_in,
  input  logic [7:0]            brightness,
  output logic                  tick_o,
  output logic [NUM_CH-1:0]     led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] S_LOAD = SW'(STRETCH_TICKS);

  if (DIV < 2) begin : g_div_chk
    $error("led_status_ctrl: CLK_HZ/TICK_HZ must be >= 2");
  end
  if (STRETCH_TICKS < 1) begin : g_stretch_chk
    $error("led_status_ctrl: STRETCH_TICKS must be >= 1");
  end

  logic [PW-1:0]             pcnt;
  logic [HP_W-1:0]           bcnt;
  logic [HP_W-1:0]           hp_last;
  logic                      phase;
  logic [NUM_CH-1:0]         sync0;
  logic [NUM_CH-1:0]         sync1;
  logic [NUM_CH-1:0]         prev;
  logic [NUM_CH-1:0]         rise;
  logic [NUM_CH-1:0][SW-1:0] scnt;
  logic [NUM_CH-1:0]         led_raw;
  logic                      pwm_gate;

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      pcnt   <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= (pcnt == P_LAST);
      pcnt   <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
    end
  end

  // A zero half-period behaves as one; >= (not ==) means shrinking it never wraps bcnt.
  assign hp_last = (half_period == '0) ? '0 : half_period - 1'b1;

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (tick_o) begin
      if (bcnt >= hp_last) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      sync0 <= '0;
      sync1 <= '0;
      prev  <= '0;
    end else begin
      sync0 <= event_in;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign rise = sync1 & ~prev;

  // A fresh edge reloads the full count even when it lands on a tick.
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      scnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise[i]) begin
          scnt[i] <= S_LOAD;
        end else if (tick_o && (scnt[i] != '0)) begin
          scnt[i] <= scnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode[2*i +: 2])
        2'b00:   led_raw[i] = 1'b0;
        2'b01:   led_raw[i] = 1'b1;
        2'b10:   led_raw[i] = phase;
        default: led_raw[i] = (scnt[i] != '0);
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign pwm_gate = (pwm_cnt < brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_gate          = 1'b1;
`endif

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      led <= '0;
    end else begin
      led <= led_raw & {NUM_CH{pwm_gate}};
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb/tb_led_status_ctrl.sv - directed self-checking bench for led_status_ctrl
module tb_led_status_ctrl;

  logic        fpga_clk_50 = 1'b0;
  logic        hps_fpga_reset_n = 1'b0;
  logic [7:0]  mode = '0;
  logic [15:0] half_period = '0;
  logic [3:0]  event_in = '0;
  logic [7:0]  brightness = 8'd255;
  logic        tick_o;
  logic [3:0]  led;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 fpga_clk_50 = ~fpga_clk_50;

  led_status_ctrl #(
    .NUM_CH(4), .CLK_HZ(100), .TICK_HZ(10), .STRETCH_TICKS(3), .HP_W(16)
  ) dut (
    .fpga_clk_50(fpga_clk_50),
    .hps_fpga_reset_n(hps_fpga_reset_n),
    .mode(mode),
    .half_period(half_period),
    .event_in(event_in),
    .brightness(brightness),
    .tick_o(tick_o),
    .led(led)
  );

  task automatic step();
    @(posedge fpga_clk_50);
    @(negedge fpga_clk_50);
    cyc++;
  endtask

  task automatic apply_reset();
    hps_fpga_reset_n = 1'b0;
    @(negedge fpga_clk_50);
    @(negedge fpga_clk_50);
    hps_fpga_reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    @(negedge fpga_clk_50);
    checks++;
    if (led !== 4'b0000) begin
      errors++; $display("FAIL reset_led got=%b exp=0000", led);
    end
    checks++;
    if (tick_o !== 1'b0) begin
      errors++; $display("FAIL reset_tick got=%b exp=0", tick_o);
    end
    hps_fpga_reset_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 35; k++) begin
      step();
      exp_tick = (cyc % 10 == 0);
      checks++;
      if (tick_o !== exp_tick) begin
        errors++; $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick_o, exp_tick);
      end
      checks++;
      if (led !== 4'b0000) begin
        errors++; $display("FAIL idle_led cyc=%0d got=%b exp=0000", cyc, led);
      end
    end
  endtask

  task automatic test_mode();
    mode = 8'b00_00_00_01;
    step();
    checks++;
    if (led !== 4'b0001) begin
      errors++; $display("FAIL mode_on got=%b exp=0001", led);
    end
    step();
    #2 hps_fpga_reset_n = 1'b0;
    #1;
    checks++;
    if (led !== 4'b0000) begin
      errors++; $display("FAIL async_reset_led got=%b exp=0000", led);
    end
    checks++;
    if (tick_o !== 1'b0) begin
      errors++; $display("FAIL async_reset_tick got=%b exp=0", tick_o);
    end
    @(negedge fpga_clk_50);
    mode = '0;
    @(negedge fpga_clk_50);
    hps_fpga_reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_blink();
    logic exp;
    mode = 8'b00_10_00_00;
    half_period = 16'd2;
    while (cyc < 165) begin
      step();
      if (cyc <= 82)       exp = (cyc >= 22 && cyc < 42) || (cyc >= 62 && cyc < 82);
      else if (cyc <= 115) exp = (cyc >= 92 && cyc < 102) || (cyc >= 112);
      else if (cyc <= 145) exp = 1'b1;
      else                 exp = (cyc < 152) || (cyc >= 162);
      checks++;
      if (led[2] !== exp) begin
        errors++; $display("FAIL blink cyc=%0d hp=%0d got=%b exp=%b", cyc, half_period, led[2], exp);
      end
      if (cyc == 82)  half_period = 16'd0;
      if (cyc == 115) half_period = 16'd5;
      if (cyc == 145) half_period = 16'd1;
    end
  endtask

  task automatic test_stretch();
    logic exp;
    mode = 8'b11_00_00_00;
    half_period = 16'd0;
    event_in = '0;
    apply_reset();
    while (cyc < 175) begin
      step();
      exp = (cyc >= 6 && cyc <= 31) || (cyc >= 44 && cyc <= 91) || (cyc >= 102 && cyc <= 131) ||
            (cyc >= 144 && cyc <= 145) || (cyc >= 156 && cyc <= 171);
      checks++;
      if (led[3] !== exp) begin
        errors++; $display("FAIL stretch cyc=%0d got=%b exp=%b", cyc, led[3], exp);
      end
      event_in[3] = (cyc == 2) || (cyc == 3) || (cyc == 40) || (cyc == 41) || (cyc == 62) || (cyc == 63) ||
                    (cyc == 98) || (cyc == 99) || (cyc == 140) || (cyc == 141);
      if (cyc == 145) mode = 8'b00_00_00_00;
      if (cyc == 155) mode = 8'b11_00_00_00;
    end
  endtask

  task automatic test_pwm();
    mode = 8'b00_00_00_01;
    event_in = '0;
`ifdef LED_PWM_EN
    begin
      int highs;
      logic exp;
      highs = 0;
      brightness = 8'd64;
      apply_reset();
      for (int k = 0; k < 256; k++) begin
        step();
        exp = (((cyc - 1) % 256) < 64);
        if (led[0] === 1'b1) highs++;
        checks++;
        if (led[0] !== exp) begin
          errors++; $display("FAIL pwm64 cyc=%0d got=%b exp=%b", cyc, led[0], exp);
        end
      end
      checks++;
      if (highs !== 64) begin
        errors++; $display("FAIL pwm64_duty got=%0d exp=64", highs);
      end
      brightness = 8'd0;
      for (int k = 0; k < 20; k++) begin
        step();
        checks++;
        if (led[0] !== 1'b0) begin
          errors++; $display("FAIL pwm0 cyc=%0d got=%b exp=0", cyc, led[0]);
        end
      end
    end
`else
    brightness = 8'd0;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (led[0] !== 1'b1) begin
        errors++; $display("FAIL nopwm cyc=%0d got=%b exp=1", cyc, led[0]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mode();
    test_blink();
    test_stretch();
    test_pwm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Parametrised, multi-channel successor to the single-LED 1 Hz heartbeat in the DE10 top level.
- Drives NUM_CH board LEDs. Each channel is independently set by an HPS PIO word to one of four modes: off, on, blink, or event pulse-stretch.
- Lets Game of Life status signals (start, completed, write_enable) show up on LEDs at human-visible rates.
- Sits in the DE10 top beside soc_system and GameOfLifeWrapper, clocked from fpga_clk_50.

Parameters:
- NUM_CH, 8, number of LED channels.
- CLK_HZ, 50000000, clock frequency in Hz.
- TICK_HZ, 1000, base tick rate. Prescaler divisor DIV = CLK_HZ/TICK_HZ; must be >= 2.
- STRETCH_TICKS, 50, number of ticks an event keeps its LED lit; must be >= 1.
- HP_W, 16, width of half_period.

Ports:
- fpga_clk_50, in, 1, clock.
- hps_fpga_reset_n, in, 1, reset; asynchronous, active-low.
- mode, in, 2*NUM_CH, per-channel mode; bits [2i+1:2i] belong to channel i. 00 = off, 01 = on, 10 = blink, 11 = stretch.
- half_period, in, HP_W, blink half-period in ticks; 0 is treated as 1.
- event_in, in, NUM_CH, per-channel asynchronous event inputs.
- brightness, in, 8, PWM duty (used only with LED_PWM_EN).
- tick_o, out, 1, one-cycle tick pulse for other blocks.
- led, out, NUM_CH, registered LED drive.

Behaviour:
- Reset (async assert, sync deassert handled by top): led = 0, tick_o = 0. Prescaler, blink counter, blink phase, sync flops and all stretch counters = 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick_o is registered and high for exactly one cycle when the prescaler value equals DIV-1.
  - First tick occurs DIV cycles after reset release.
- Blink generator:
  - Shared by all channels, so every blinking LED is in phase.
  - On each tick: if bcnt >= max(half_period,1)-1, then bcnt <= 0 and phase toggles; else bcnt increments.
  - A half_period reduced below the current bcnt causes a toggle at the next tick. No stall, no wrap through 2^HP_W.
- Event path, per channel:
  - event_in goes through a 2-flop synchroniser; rising edge = sync1 & ~prev.
  - On a rising edge, scnt <= STRETCH_TICKS. Otherwise, on a tick with scnt != 0, scnt decrements.
  - Edge and tick in the same cycle: load wins.
  - A retrigger while active restarts the full count.
  - Edge detection runs in every mode, but only affects led in mode 11.
- Output register, per channel, next led value:
  - 00 → 0
  - 01 → 1
  - 10 → phase
  - 11 → (scnt != 0)
- Latency:
  - mode change → led reflects it 1 cycle later.
  - event_in high before clock edge 1 → led high after edge 4.
- led falls on the cycle after the tick that decrements scnt to 0.
- A mode change mid-stretch does not clear scnt. Returning to 11 shows any remaining count.
- Counter widths: $clog2(DIV), HP_W, $clog2(STRETCH_TICKS+1). No counter may overflow.

Optional Feature:
- Macro LED_PWM_EN.
- Defined:
  - A free-running 8-bit pwm counter increments every cycle and wraps 255→0.
  - led[i] = led_raw[i] & (pwm_cnt < brightness). brightness 0 forces all LEDs off; 255 gives 255/256 duty.
  - The gating is applied in the output register, so latency is unchanged.
- Undefined:
  - No PWM counter; brightness is ignored.
  - led = led_raw.

Test Plan:
Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), STRETCH_TICKS=3, NUM_CH=4.
1. Reset release, mode=0 → led=0 throughout. tick_o pulses at cycles 10, 20, 30..., each exactly 1 cycle wide.
2. mode ch0=01, ch1=00 → led[0]=1 and led[1]=0 one cycle after mode is applied. Assert reset mid-run → led=0 immediately, asynchronously.
3. ch2=10, half_period=2 → led[2] toggles every 2 ticks (20 cycles high, 20 low). half_period=0 → toggles every tick. Change half_period from 5 to 1 while bcnt=3 → toggles at the next tick.
4. ch3=11, event_in[3] 1-cycle-wide pulse (held 2 cycles for sync) → led[3] high 4 edges after the pulse, low after the 3rd subsequent tick. Retrigger after 2 ticks → high for 3 more ticks. Edge coincident with a tick → count reloads to 3.
5. LED_PWM_EN, ch0=01: brightness=64 → led[0] high for 64 of every 256 cycles; brightness=0 → always 0. Without the macro, brightness=0 → led[0] constantly 1.
